// File: rtl/data_bus.sv
// Data-side memory subsystem: word RAM plus MMIO (UART TX FIFO, cycle counter, halt flag).
// Reads combinational (0 cycles), writes commit at the edge; UART pushes to a full FIFO are dropped.

module fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_vld,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop_rdy,
   output logic [WIDTH-1:0] head_dat,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);
   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr, rd_ptr;
   logic             push_ok, pop_ok;

   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);
   assign head_dat = mem[rd_ptr];
   // A push is refused whenever full, regardless of a concurrent pop.
   assign push_ok  = push_vld && !full;
   assign pop_ok   = pop_rdy && !empty;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(push_ok) - CW'(pop_ok);
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_dat;
   end
endmodule

module data_bus #(
   parameter int RAM_WORDS  = 1024,
   parameter int FIFO_DEPTH = 8,
   parameter int BAUD_DIV   = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_en,
   input  logic [31:0] addr,
   input  logic [31:0] mem_data,
   input  logic        req,
   output logic [31:0] mem_out,
   output logic        tx,
   output logic        halted
);
   localparam int AW = $clog2(RAM_WORDS);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int DW = $clog2(BAUD_DIV);
   localparam logic [29:0] UART_DATA_W   = 30'h3FFF_C000;
   localparam logic [29:0] UART_STATUS_W = 30'h3FFF_C001;
   localparam logic [29:0] CYCLE_W       = 30'h3FFF_C002;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

   logic [31:0]   ram [RAM_WORDS];
   logic [29:0]   word;
   logic [AW-1:0] ram_idx;
   logic          ram_sel, wr_ok, push_vld;
   logic [31:0]   cycle, status;
   logic          overflow;
   logic          unused_addr;

   logic [7:0]    head_dat;
   logic          fifo_full, fifo_empty, pop;
   logic [CW-1:0] fifo_cnt;

   uart_state_t   state, state_nxt;
   logic [DW-1:0] div, div_nxt;
   logic [2:0]    bit_cnt, bit_nxt;
   logic [7:0]    shreg, sh_nxt;
   logic          tx_line, div_done;

   assign word        = addr[31:2];
   assign unused_addr = ^addr[1:0];
   assign ram_idx     = addr[AW+1:2];
   assign ram_sel     = (addr[31:AW+2] == '0);
   assign wr_ok       = mem_en && !halted;
   assign push_vld    = wr_ok && (word == UART_DATA_W);

   always_ff @(posedge clk) begin
      if (wr_ok && ram_sel) ram[ram_idx] <= mem_data;
   end

   assign status = {16'h0, 8'(fifo_cnt), 5'h0, overflow, fifo_full,
                    (state == IDLE) && fifo_empty};

   always_comb begin
      mem_out = '0;
      if (ram_sel)                     mem_out = ram[ram_idx];
      else if (word == UART_STATUS_W)  mem_out = status;
      else if (word == CYCLE_W)        mem_out = cycle;
   end

   // The write that accompanies req still lands, since halted only rises at this edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         halted   <= 1'b0;
         overflow <= 1'b0;
         cycle    <= '0;
      end else begin
         if (req)                     halted   <= 1'b1;
         if (!halted)                 cycle    <= cycle + 32'd1;
         if (push_vld && fifo_full)   overflow <= 1'b1;
      end
   end

   fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8), .CW(CW)) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push_vld (push_vld),
      .push_dat (mem_data[7:0]),
      .pop_rdy  (pop),
      .head_dat (head_dat),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .count    (fifo_cnt)
   );

   assign div_done = (div == DW'(BAUD_DIV - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         div     <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
         tx      <= 1'b1;
      end else begin
         state   <= state_nxt;
         div     <= div_nxt;
         bit_cnt <= bit_nxt;
         shreg   <= sh_nxt;
         tx      <= tx_line;
      end
   end

   always_comb begin
      state_nxt = state;
      div_nxt   = div;
      bit_nxt   = bit_cnt;
      sh_nxt    = shreg;
      pop       = 1'b0;
      tx_line   = 1'b1;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               pop       = 1'b1;
               sh_nxt    = head_dat;
               div_nxt   = '0;
               state_nxt = START;
            end
         end
         START: begin
            tx_line = 1'b0;
            if (div_done) begin
               div_nxt   = '0;
               bit_nxt   = '0;
               state_nxt = DATA;
            end else begin
               div_nxt = div + DW'(1);
            end
         end
         DATA: begin
            tx_line = shreg[0];
            if (div_done) begin
               div_nxt = '0;
               sh_nxt  = {1'b0, shreg[7:1]};
               bit_nxt = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) state_nxt = STOP;
            end else begin
               div_nxt = div + DW'(1);
            end
         end
         STOP: begin
            if (div_done) begin
               div_nxt   = '0;
               state_nxt = IDLE;
            end else begin
               div_nxt = div + DW'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end
endmodule

// File: tb/tb_data_bus.sv
// Directed/random bench for data_bus: RAM, MMIO decode, UART framing, overflow, halt, reset mid-frame.
module tb_data_bus;
   localparam int WORDS = 1024;
   localparam int DEPTH = 8;
   localparam int BAUD  = 4;
   localparam logic [31:0] A_DATA   = 32'hFFFF_0000;
   localparam logic [31:0] A_STATUS = 32'hFFFF_0004;
   localparam logic [31:0] A_CYCLE  = 32'hFFFF_0008;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        mem_en = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] mem_data = '0;
   logic        req = 1'b0;
   logic [31:0] mem_out;
   logic        tx;
   logic        halted;

   int vectors = 0;
   int miscompares = 0;
   int frame_err = 0;

   logic [31:0] ram_m [int];
   logic [31:0] exp_cycle = '0;
   bit          m_halt = 1'b0;
   logic [7:0]  exp_q [$];
   logic [7:0]  rx_q [$];

   data_bus #(.RAM_WORDS(WORDS), .FIFO_DEPTH(DEPTH), .BAUD_DIV(BAUD)) dut (
      .clk      (clk),
      .reset    (reset),
      .mem_en   (mem_en),
      .addr     (addr),
      .mem_data (mem_data),
      .req      (req),
      .mem_out  (mem_out),
      .tx       (tx),
      .halted   (halted)
   );

   always #5 clk = ~clk;

   // Line-level receiver: mid-bit sampling, abandons any frame cut by reset.
   always begin : uart_mon
      logic [7:0] b;
      bit ab;
      @(negedge clk);
      if (!reset && tx === 1'b0) begin
         ab = 1'b0;
         b  = '0;
         repeat (BAUD / 2) begin @(negedge clk); if (reset) ab = 1'b1; end
         if (tx !== 1'b0) ab = 1'b1;
         for (int k = 0; k < 8; k++) begin
            repeat (BAUD) begin @(negedge clk); if (reset) ab = 1'b1; end
            b[k] = tx;
         end
         repeat (BAUD) begin @(negedge clk); if (reset) ab = 1'b1; end
         if (!ab) begin
            if (tx === 1'b1) rx_q.push_back(b);
            else frame_err++;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic step();
      if (reset) begin
         exp_cycle = '0;
         m_halt    = 1'b0;
      end else begin
         if (!m_halt) exp_cycle = exp_cycle + 32'd1;
         if (req) m_halt = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      mem_en = 1'b0;
      addr   = a;
      #1;
      d = mem_out;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic rq,
                     output logic [31:0] same);
      mem_en = 1'b1; addr = a; mem_data = d; req = rq;
      #1;
      same = mem_out;
      if (!m_halt && a < WORDS * 4) ram_m[int'(a >> 2)] = d;
      step();
      mem_en = 1'b0; req = 1'b0;
   endtask

   task automatic drain(input int budget);
      logic [31:0] s;
      bit done;
      done = 1'b0;
      s = '0;
      for (int i = 0; i < budget && !done; i++) begin
         rd(A_STATUS, s);
         if (s[0] === 1'b1) done = 1'b1;
         else step();
      end
      chk("drain_idle", {31'h0, s[0]}, 32'h1);
      repeat (3) step();
   endtask

   task automatic cmp_rx();
      chk("rx_count", 32'(rx_q.size()), 32'(exp_q.size()));
      while (exp_q.size() > 0 && rx_q.size() > 0)
         chk("rx_byte", 32'(rx_q.pop_front()), 32'(exp_q.pop_front()));
      rx_q.delete();
      exp_q.delete();
   endtask

   initial begin
      logic [31:0] d, old, a, same, v;
      logic [7:0]  f, bytes [9];
      logic [9:0]  frame;
      int idx, lows;

      // Reset state and counter
      step(); step();
      reset = 1'b0;
      chk("rst_tx", {31'h0, tx}, 32'h1);
      chk("rst_halted", {31'h0, halted}, 32'h0);
      rd(A_STATUS, d); chk("rst_status", d, 32'h1);
      rd(A_CYCLE, d);  chk("rst_cycle", d, 32'h0);
      repeat (5) step();
      rd(A_CYCLE, d);  chk("cycle_at_5", d, 32'd5);
      rd(32'hFFFF_000C, d); chk("dec_ffff000c", d, 32'h0);
      rd(32'h8000_0000, d); chk("dec_80000000", d, 32'h0);
      rd(A_DATA, d);        chk("dec_uart_data", d, 32'h0);

      // RAM round trip and read-during-write
      wr(32'h10, 32'hDEAD_BEEF, 1'b0, same);
      rd(32'h10, d); chk("ram_rt", d, 32'hDEAD_BEEF);
      rd(32'h13, d); chk("ram_rt_13", d, 32'hDEAD_BEEF);
      wr(32'h10, 32'h1234_5678, 1'b0, same);
      chk("ram_rdw_old", same, 32'hDEAD_BEEF);
      rd(32'h10, d); chk("ram_rdw_new", d, 32'h1234_5678);

      for (int i = 0; i < 16; i++) begin
         idx = 64 + $urandom_range(0, 7);
         a   = {20'h0, idx[9:0], 2'($urandom_range(0, 3))};
         v   = $urandom;
         old = ram_m.exists(idx) ? ram_m[idx] : 32'h0;
         if (ram_m.exists(idx)) begin
            wr(a, v, 1'b0, same);
            chk("ram_rand_rdw", same, old);
         end else begin
            wr(a, v, 1'b0, same);
         end
         rd({a[31:2], 2'($urandom_range(0, 3))}, d); chk("ram_rand", d, v);
         rd(A_CYCLE, d); chk("cycle_run", d, exp_cycle);
         a = 32'h8000_0000 | 32'($urandom);
         if (a[31:4] == 28'hFFFF000) a = 32'h8000_0000;
         rd(a, d); chk("dec_rand_hole", d, 32'h0);
      end

      // Single UART byte 0xA5
      wr(A_DATA, 32'h0000_00A5, 1'b0, same);
      exp_q.push_back(8'hA5);
      rd(A_STATUS, d); chk("uart_occ1", d, 32'h0000_0100);
      step();
      chk("uart_tx_hi_e1", {31'h0, tx}, 32'h1);
      step();
      frame = {1'b1, 8'hA5, 1'b0};
      lows = 0;
      for (int i = 0; i < 10 * BAUD; i++) begin
         if (tx !== frame[i / BAUD]) lows++;
         step();
      end
      chk("uart_frame_bits", 32'(lows), 32'h0);
      chk("uart_tx_after", {31'h0, tx}, 32'h1);
      rd(A_STATUS, d); chk("uart_idle_after", d, 32'h1);
      cmp_rx();

      // Overflow: nine pushes while a frame is in flight
      f = 8'($urandom);
      wr(A_DATA, {24'h0, f}, 1'b0, same);
      exp_q.push_back(f);
      repeat (3) step();
      for (int i = 0; i < 9; i++) begin
         bytes[i] = 8'($urandom);
         wr(A_DATA, {24'h0, bytes[i]}, 1'b0, same);
         if (i < DEPTH) exp_q.push_back(bytes[i]);
      end
      rd(A_STATUS, d); chk("ovf_status", d, 32'h0000_0806);
      drain(1000);
      rd(A_STATUS, d); chk("ovf_sticky", d, 32'h0000_0005);
      cmp_rx();

      // Halt
      wr(32'h200, 32'hCAFE_0001, 1'b0, same);
      f = 8'($urandom);
      wr(A_DATA, {24'h0, f}, 1'b0, same);
      exp_q.push_back(f);
      wr(32'h204, 32'hCAFE_0002, 1'b1, same);
      chk("halt_set", {31'h0, halted}, 32'h1);
      wr(32'h200, 32'h0BAD_0BAD, 1'b0, same);
      wr(A_DATA, 32'h77, 1'b0, same);
      rd(A_STATUS, d); chk("halt_no_push", d & 32'h0000_FF02, 32'h0);
      rd(32'h200, d); chk("halt_ram_kept", d, 32'hCAFE_0001);
      rd(32'h204, d); chk("halt_req_write", d, 32'hCAFE_0002);
      rd(A_CYCLE, d); chk("halt_cycle_a", d, exp_cycle);
      step();
      rd(A_CYCLE, d); chk("halt_cycle_b", d, exp_cycle);
      drain(200);
      cmp_rx();
      chk("halt_sticky", {31'h0, halted}, 32'h1);

      // Reset during DATA
      reset = 1'b1; step(); reset = 1'b0;
      chk("rst2_halted", {31'h0, halted}, 32'h0);
      wr(A_DATA, 32'h0000_003C, 1'b0, same);
      repeat (8) step();
      reset = 1'b1; step(); reset = 1'b0;
      chk("midrst_tx", {31'h0, tx}, 32'h1);
      rd(A_STATUS, d); chk("midrst_status", d, 32'h0000_0001);
      lows = 0;
      for (int i = 0; i < 60; i++) begin
         if (tx !== 1'b1) lows++;
         step();
      end
      chk("midrst_no_residual", 32'(lows), 32'h0);
      chk("midrst_rx_empty", 32'(rx_q.size()), 32'h0);
      chk("frame_err", 32'(frame_err), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/data_bus.md
# data_bus

Data-side memory subsystem for the pipelined MIPS core, sitting directly downstream of the datapath's memory stage and consuming its `mem_en`, `addr`, `mem_data` and `req` outputs. It decodes each access onto a word-addressed data RAM or a small MMIO window. The MMIO window contains a byte FIFO feeding an 8N1 UART transmitter, a free-running cycle counter and a sticky halt flag. Reads are combinational, because the memory stage consumes `mem_out` in the same cycle it drives `addr`. Writes commit on the clock edge.

## Interface
- `RAM_WORDS`, default 1024: data RAM depth in 32-bit words; power of two.
- `FIFO_DEPTH`, default 8: UART byte FIFO depth; power of two, ≥2.
- `BAUD_DIV`, default 16: clock cycles per UART bit; ≥2.

- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `mem_en` in 1: write enable for the current access.
- `addr` in 32: byte address from the memory stage.
- `mem_data` in 32: store data.
- `req` in 1: halt request from the pipeline.
- `mem_out` out 32: combinational read data for `addr`.
- `tx` out 1: UART serial line; idles high.
- `halted` out 1: sticky halt flag.

## Operation
- **Address decode:** `addr[1:0]` is ignored (word access only).
  - RAM region: `addr < RAM_WORDS*4`, indexed by `addr[log2(RAM_WORDS)+1:2]`.
  - `0xFFFF_0000` UART_DATA. A write pushes `mem_data[7:0]`. Reads return 0.
  - `0xFFFF_0004` UART_STATUS, read-only:
    - bit0 = transmitter idle and FIFO empty.
    - bit1 = FIFO full.
    - bit2 = overflow (sticky).
    - bits[15:8] = FIFO occupancy.
    - other bits 0.
  - `0xFFFF_0008` CYCLE, read-only: 32-bit cycle counter.
  - Any other address reads 0; writes to it are dropped.
- **RAM:** no reset of contents. Write when `mem_en=1`, the address is in the RAM region and `halted=0`.
- **FIFO:** circular buffer with read and write pointers plus an occupancy count.
  - A push while full is dropped and sets overflow. This holds even if a pop occurs in the same cycle.
  - A push and a pop in the same cycle when not full leave occupancy unchanged.
- **UART FSM, states IDLE → START → DATA → STOP → IDLE:**
  - IDLE with FIFO non-empty: pop the head byte into the shift register and enter START.
  - START drives `tx=0`.
  - DATA shifts 8 bits out LSB first.
  - STOP drives `tx=1`.
  - Each of START, each DATA bit and STOP lasts exactly `BAUD_DIV` cycles, timed by a divider counter.
  - Back-to-back bytes: STOP → IDLE → START, giving one IDLE cycle between frames.
- **CYCLE:** resets to 0, increments by 1 every cycle while `halted=0`, wraps modulo 2^32.
- **Halt:** `req=1` sets `halted` at the next edge. It stays set until reset.
  - While halted, all writes (RAM and MMIO) are ignored.
  - Reads still work, and the UART keeps draining the FIFO.

## Timing
- **Reset values:**
  - `tx=1`, `halted=0`, CYCLE=0.
  - FIFO empty, overflow=0, FSM in IDLE, divider=0.
  - `mem_out` follows `addr` combinationally; with RAM contents undefined, only MMIO reads are defined right after reset.
- **Read latency:** 0 cycles; `mem_out` is combinational on `addr` and current state.
- **Read during write, same address, same cycle:** returns the old value. The following cycle returns the new value.
- **Write latency:** 1 edge. A store at edge N is visible to reads from cycle N+1.
- **UART_DATA push:**
  - Occupancy reflects the push in the cycle after the edge.
  - If the FSM is IDLE, it pops at the next edge, so `tx` falls 2 edges after the store edge.
- **Frame length:** 10×`BAUD_DIV` cycles.
- **CYCLE read:** returns the pre-edge value of the current cycle.
- **Halt:**
  - `req=1` at edge N gives `halted=1` from cycle N+1.
  - A write presented alongside `req` in the same cycle still commits.
  - CYCLE stops after the increment at edge N.
- **Reset mid-frame:** at the reset edge, `tx` returns to 1, the FSM returns to IDLE and the FIFO clears; the remainder of the frame is lost.

## Test plan
- **RAM round trip:** write `0xDEADBEEF` to `0x0000_0010`, then read `0x0000_0010` and `0x0000_0013` on the next cycle → both return `0xDEADBEEF`. A same-cycle read returns the prior value.
- **Single UART byte:** write `0x000000A5` to `0xFFFF_0000` with `BAUD_DIV=4` → `tx` goes low 2 edges later, carries bits 1,0,1,0,0,1,0,1 (4 cycles each), stop high, then status bit0=1 after 40 cycles.
- **Overflow:** push 9 bytes back-to-back with `FIFO_DEPTH=8` while the first frame is in flight → status bit2=1, occupancy ≤8, transmitted byte stream equals the first accepted bytes in order.
- **Halt:** assert `req` for one cycle, then write RAM and UART_DATA → neither changes state. CYCLE reads the same value on two consecutive cycles; `halted=1` holds.
- **Counter and decode:** after reset, read `0xFFFF_0008` at cycle 5 → 5. A read of `0xFFFF_000C` or `0x8000_0000` → 0.
- **Reset mid-frame:** assert `reset` during DATA → `tx=1` on the next cycle, status=`0x00000001`, and no residual frame follows.
